// File: rtl/dac_frame_scheduler.sv
// Dual-channel MCP4922 frame sequencer: tick generator, sample fetch, two SPI words, LDAC pulse.
// Optional DAC_SHUTDOWN_EN: disabled channels get a shutdown word instead of being skipped.
`timescale 1ns/1ps

module dac_frame_scheduler #(
  parameter int unsigned LDAC_CYCLES = 2,
  parameter int unsigned PERIOD_MIN  = 64
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [1:0]  chan_en,
  output logic        sample_req,
  input  logic        sample_valid,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  output logic [15:0] spi_word,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        ldac_n,
  output logic        busy,
  output logic        overrun,
  input  logic        clear_overrun,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND_A, WAIT_A, SEND_B, WAIT_B, LATCH
  } state_e;

  localparam logic [31:0] PERIOD_FLOOR = 32'(PERIOD_MIN);
  localparam logic [7:0]  LDAC_LAST    = 8'(LDAC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_eff, period_last;
  logic        tick;
  logic [1:0]  chan_q, chan_d;
  logic [11:0] sa_q, sa_d;
  logic [11:0] sb_q, sb_d;
  logic [15:0] word_q, word_d;
  logic [15:0] word_a, word_b;
  logic        start_q, start_d;
  logic        ldac_n_q, ldac_n_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [15:0] frame_count_q, frame_count_d;

  // A period shrinking below the current count fires on the next cycle via >=.
  always_comb begin
    period_eff  = (period < PERIOD_FLOOR) ? PERIOD_FLOOR : period;
    period_last = period_eff - 32'd1;
    tick        = enable && (cnt_q >= period_last);
    cnt_d       = (!enable || tick) ? 32'd0 : cnt_q + 32'd1;
  end

`ifdef DAC_SHUTDOWN_EN
  assign word_a = chan_q[0] ? {4'b0011, sa_q} : 16'h2000;
  assign word_b = chan_q[1] ? {4'b1011, sb_q} : 16'hA000;
`else
  assign word_a = {4'b0011, sa_q};
  assign word_b = {4'b1011, sb_q};
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    chan_d        = chan_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    word_d        = word_q;
    start_d       = 1'b0;
    lcnt_d        = 8'd0;
    frame_count_d = frame_count_q;

    overrun_d = overrun_q;
    if (clear_overrun)              overrun_d = 1'b0;
    if (tick && (state_q != IDLE))  overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick && (chan_en != 2'b00)) begin
          chan_d  = chan_en;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (sample_valid) begin
          sa_d = sample_a;
          sb_d = sample_b;
`ifdef DAC_SHUTDOWN_EN
          state_d = SEND_A;
`else
          state_d = chan_q[0] ? SEND_A : SEND_B;
`endif
        end
      end
      SEND_A: begin
        if (!spi_busy) begin
          word_d  = word_a;
          start_d = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_A: begin
        if (spi_done) begin
`ifdef DAC_SHUTDOWN_EN
          state_d = SEND_B;
`else
          state_d = chan_q[1] ? SEND_B : LATCH;
`endif
        end
      end
      SEND_B: begin
        if (!spi_busy) begin
          word_d  = word_b;
          start_d = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (spi_done) state_d = LATCH;
      end
      LATCH: begin
        if (lcnt_q == LDAC_LAST) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end else begin
          lcnt_d = lcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from next state so ldac_n is low exactly while the FSM sits in LATCH.
    ldac_n_d = (state_d != LATCH);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      // NOTE: all holding registers (samples, channel mask) are reset too; they are flops, not RAM.
      state_q       <= IDLE;
      cnt_q         <= 32'd0;
      chan_q        <= 2'b00;
      sa_q          <= 12'd0;
      sb_q          <= 12'd0;
      word_q        <= 16'd0;
      start_q       <= 1'b0;
      ldac_n_q      <= 1'b1;
      overrun_q     <= 1'b0;
      lcnt_q        <= 8'd0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      chan_q        <= chan_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      word_q        <= word_d;
      start_q       <= start_d;
      ldac_n_q      <= ldac_n_d;
      overrun_q     <= overrun_d;
      lcnt_q        <= lcnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sample_req  = (state_q == FETCH);
  assign busy        = (state_q != IDLE);
  assign spi_word    = word_q;
  assign spi_start   = start_q;
  assign ldac_n      = ldac_n_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler: behavioural SPI serializer, word/LDAC monitor,
// a vector table of single frames plus hand-written overrun, busy, reset and wrap sequences.
`timescale 1ns/1ps

module tb_dac_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd100;
  logic [1:0]  chan_en = 2'b00;
  logic        sample_req;
  logic        sample_valid = 1'b1;
  logic [11:0] sample_a = 12'd0;
  logic [11:0] sample_b = 12'd0;
  logic [15:0] spi_word;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic        ldac_n;
  logic        busy;
  logic        overrun;
  logic        clear_overrun = 1'b0;
  logic [15:0] frame_count;

  logic ser_busy;
  logic ext_busy = 1'b0;
  int   done_delay = 20;
  int   ser_cnt;
  int   cyc = 0;

  assign spi_busy = ser_busy | ext_busy;

  dac_frame_scheduler dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .enable        (enable),
    .period        (period),
    .chan_en       (chan_en),
    .sample_req    (sample_req),
    .sample_valid  (sample_valid),
    .sample_a      (sample_a),
    .sample_b      (sample_b),
    .spi_word      (spi_word),
    .spi_start     (spi_start),
    .spi_busy      (spi_busy),
    .spi_done      (spi_done),
    .ldac_n        (ldac_n),
    .busy          (busy),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .frame_count   (frame_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Serializer model: busy from the edge after spi_start until it pulses spi_done.
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ser_busy <= 1'b0;
      spi_done <= 1'b0;
      ser_cnt  <= 0;
    end else begin
      spi_done <= 1'b0;
      if (ser_busy) begin
        if (ser_cnt >= done_delay) begin
          ser_busy <= 1'b0;
          spi_done <= 1'b1;
        end else begin
          ser_cnt <= ser_cnt + 1;
        end
      end else if (spi_start) begin
        ser_busy <= 1'b1;
        ser_cnt  <= 1;
      end
    end
  end

  logic [15:0] words[$];
  int          stamps[$];
  int          ldac_widths[$];
  int          ldac_run = 0;
  int          busy_viol = 0;

  always @(negedge CLK) begin
    if (spi_start) begin
      words.push_back(spi_word);
      stamps.push_back(cyc);
      if (spi_busy) busy_viol++;
    end
    if (!ldac_n) ldac_run++;
    else if (ldac_run != 0) begin
      ldac_widths.push_back(ldac_run);
      ldac_run = 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [15:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 16'hDEAD;
  endfunction

  function automatic int stamp_at(input int i);
    if (i < stamps.size()) return stamps[i];
    return -1;
  endfunction

  function automatic int ldac_at(input int i);
    if (i < ldac_widths.size()) return ldac_widths[i];
    return -1;
  endfunction

  task automatic wait_fc(input logic [15:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (frame_count !== target && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(frame_count), 32'(target));
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (words.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, words.size(), n);
  endtask

  typedef struct {
    logic [1:0]  chan;
    logic [11:0] a;
    logic [11:0] b;
    int          n;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_fc;
    int base, lbase, e, r;

`ifdef DAC_SHUTDOWN_EN
    vecs[0] = '{chan: 2'b10, a: 12'h456, b: 12'hFFF, n: 2, w0: 16'h2000, w1: 16'hBFFF};
    vecs[1] = '{chan: 2'b01, a: 12'hABC, b: 12'h777, n: 2, w0: 16'h3ABC, w1: 16'hA000};
`else
    vecs[0] = '{chan: 2'b10, a: 12'h456, b: 12'hFFF, n: 1, w0: 16'hBFFF, w1: 16'h0000};
    vecs[1] = '{chan: 2'b01, a: 12'hABC, b: 12'h777, n: 1, w0: 16'h3ABC, w1: 16'h0000};
`endif
    vecs[2] = '{chan: 2'b11, a: 12'h000, b: 12'hFFF, n: 2, w0: 16'h3000, w1: 16'hBFFF};
    vecs[3] = '{chan: 2'b11, a: 12'hFFF, b: 12'h000, n: 2, w0: 16'h3FFF, w1: 16'hB000};
    exp_fc = 16'd0;

    // Reset values
    repeat (3) step();
    check("rst sample_req", 32'(sample_req), 32'd0);
    check("rst spi_word", 32'(spi_word), 32'd0);
    check("rst spi_start", 32'(spi_start), 32'd0);
    check("rst ldac_n", 32'(ldac_n), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst frame_count", 32'(frame_count), 32'd0);
    RESETN = 1'b1;
    step();

    // Basic frame: period 100, both channels, 20-cycle serializer
    period = 32'd100; chan_en = 2'b11; sample_a = 12'h800; sample_b = 12'h123; done_delay = 20;
    base = words.size(); lbase = ldac_widths.size();
    e = cyc;
    enable = 1'b1;
    exp_fc = 16'd1;
    wait_fc(exp_fc, 400, "basic frame done");
    check("basic word A", 32'(word_at(base)), 32'h3800);
    check("basic word B", 32'(word_at(base + 1)), 32'hB123);
    check("basic tick-to-start latency", stamp_at(base) - e, 102);
    check("basic ldac width", ldac_at(lbase), 2);
    check("basic overrun", 32'(overrun), 32'd0);
    exp_fc = 16'd2;
    wait_fc(exp_fc, 300, "basic second frame");
    enable = 1'b0;
    check("basic start spacing", stamp_at(base + 2) - stamp_at(base), 100);
    repeat (5) step();

    // Vector table: one frame per entry at the clamped minimum period
    period = 32'd64; done_delay = 4;
    for (int i = 0; i < 4; i++) begin
      chan_en = vecs[i].chan; sample_a = vecs[i].a; sample_b = vecs[i].b;
      base = words.size(); lbase = ldac_widths.size();
      enable = 1'b1;
      exp_fc = exp_fc + 16'd1;
      wait_fc(exp_fc, 200, $sformatf("vec%0d frame done", i));
      enable = 1'b0;
      repeat (5) step();
      check($sformatf("vec%0d word count", i), words.size() - base, vecs[i].n);
      check($sformatf("vec%0d word0", i), 32'(word_at(base)), 32'(vecs[i].w0));
      if (vecs[i].n == 2)
        check($sformatf("vec%0d word1", i), 32'(word_at(base + 1)), 32'(vecs[i].w1));
      check($sformatf("vec%0d ldac width", i), ldac_at(lbase), 2);
    end

    // Overrun: period 10 clamps to 64, slow serializer makes the next tick land mid-frame
    period = 32'd10; chan_en = 2'b11; sample_a = 12'h555; sample_b = 12'hAAA; done_delay = 40;
    base = words.size();
    e = cyc;
    enable = 1'b1;
    exp_fc = exp_fc + 16'd1;
    wait_fc(exp_fc, 400, "overrun frame done");
    enable = 1'b0;
    check("overrun clamp latency", stamp_at(base) - e, 66);
    check("overrun set", 32'(overrun), 32'd1);
    repeat (80) step();
    check("overrun dropped tick", words.size() - base, 2);
    check("overrun sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("overrun cleared", 32'(overrun), 32'd0);

    // Serializer busy held across SEND_A
    period = 32'd64; chan_en = 2'b11; sample_a = 12'h321; sample_b = 12'h654; done_delay = 4;
    base = words.size();
    ext_busy = 1'b1;
    e = cyc;
    enable = 1'b1;
    repeat (95) step();
    check("busy hold no start", words.size() - base, 0);
    check("busy hold fsm busy", 32'(busy), 32'd1);
    check("busy hold sample_req", 32'(sample_req), 32'd0);
    ext_busy = 1'b0;
    exp_fc = exp_fc + 16'd1;
    wait_fc(exp_fc, 200, "busy hold frame done");
    enable = 1'b0;
    repeat (5) step();
    check("busy hold start time", stamp_at(base) - e, 96);
    check("busy hold word count", words.size() - base, 2);
    check("start while busy", busy_viol, 0);

    // Reset while waiting on channel B
    done_delay = 20; chan_en = 2'b11; sample_a = 12'h0F0; sample_b = 12'h00F;
    base = words.size();
    enable = 1'b1;
    wait_words(base + 2, 300, "reset seq B started");
    repeat (3) step();
    check("reset seq busy before", 32'(busy), 32'd1);
    RESETN = 1'b0;
    #1;
    check("reset seq ldac_n", 32'(ldac_n), 32'd1);
    check("reset seq spi_start", 32'(spi_start), 32'd0);
    check("reset seq spi_word", 32'(spi_word), 32'd0);
    check("reset seq busy", 32'(busy), 32'd0);
    check("reset seq sample_req", 32'(sample_req), 32'd0);
    check("reset seq frame_count", 32'(frame_count), 32'd0);
    exp_fc = 16'd0;
    step();
    RESETN = 1'b1;
    r = cyc;
    wait_words(base + 3, 200, "reset seq restart");
    check("reset seq restart time", stamp_at(base + 2) - r, 66);
    exp_fc = 16'd1;
    wait_fc(exp_fc, 200, "reset seq frame done");
    enable = 1'b0;
    repeat (5) step();

    // frame_count wrap from a preloaded 0xFFFF, then an empty-mask tick
    force dut.frame_count_q = 16'hFFFF;
    step();
    release dut.frame_count_q;
    step();
    check("wrap preload", 32'(frame_count), 32'hFFFF);
    chan_en = 2'b11;
    enable = 1'b1;
    exp_fc = 16'h0000;
    wait_fc(exp_fc, 200, "wrap to zero");
    enable = 1'b0;
    repeat (5) step();
    chan_en = 2'b00;
    base = words.size(); lbase = ldac_widths.size();
    enable = 1'b1;
    repeat (80) step();
    enable = 1'b0;
    check("empty mask frame_count", 32'(frame_count), 32'(exp_fc));
    check("empty mask no words", words.size() - base, 0);
    check("empty mask no ldac", ldac_widths.size() - lbase, 0);
    check("empty mask idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
